// File: rtl/hfosc_switch_ctrl.sv
// hfosc_switch_ctrl
//   Power-mode sequencer for moving the system between the always-on LF
//   clock and the SB_HFOSC high-frequency oscillator. Runs on the LF clock.
//   Entry: enable oscillator -> wait start-up -> switch mux -> acknowledge.
//   Exit : drop mux -> wait switchover -> disable oscillator and acknowledge.
//
// Ports
//   clk          in   LF oscillator clock (sole clock)
//   reset_n      in   asynchronous active-low reset
//   req_hf       in   level request for HF operation (4-phase handshake)
//   ack_hf       out  HF selected and stable; held until back on LF
//   hf_en        out  SB_HFOSC CLKHFEN
//   mux_sel      out  glitch-free clock mux select (1 = HF)
//   busy         out  transition in progress (START, SW_HF, SW_LF)
//   state_o      out  LF=0 START=1 SW_HF=2 HF=3 SW_LF=4
//   hf_sessions  out  number of completed entries into HF, wraps at 256
module hfosc_switch_ctrl #(
  parameter int STARTUP_CYCLES = 4,
  parameter int SWITCH_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_hf,
  output logic       ack_hf,
  output logic       hf_en,
  output logic       mux_sel,
  output logic       busy,
  output logic [2:0] state_o,
  output logic [7:0] hf_sessions
);

  localparam int MAX_CYC = (STARTUP_CYCLES > SWITCH_CYCLES) ? STARTUP_CYCLES : SWITCH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_LF    = 3'd0,
    ST_START = 3'd1,
    ST_SW_HF = 3'd2,
    ST_HF    = 3'd3,
    ST_SW_LF = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, hf_en_q, mux_sel_q, busy_q;
  logic [7:0]       sess_q;

  // Next-state and timer. A timed state loads N-1 on entry and leaves on
  // the edge where the counter reads zero, so it lasts exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LF: begin
        if (req_hf) begin
          state_d = ST_START;
          cnt_d   = CNT_W'(STARTUP_CYCLES - 1);
        end
      end
      ST_START: begin
        // An abort during start-up wins over the timer expiring, so the mux
        // is never handed a clock whose request has already gone away.
        if (!req_hf) begin
          state_d = ST_LF;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SW_HF;
          cnt_d   = CNT_W'(SWITCH_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SW_HF: begin
        // Request is not sampled mid-switch; a drop is seen once in HF.
        if (cnt_q == '0) state_d = ST_HF;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HF: begin
        if (!req_hf) begin
          state_d = ST_SW_LF;
          cnt_d   = CNT_W'(SWITCH_CYCLES - 1);
        end
      end
      ST_SW_LF: begin
        // Oscillator stays enabled while the mux drains back to LF; a
        // re-raised request is only honoured after reaching LF.
        if (cnt_q == '0) state_d = ST_LF;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_LF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so they
  // always match state_o and carry no combinational path from req_hf.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_LF;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      hf_en_q   <= 1'b0;
      mux_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      sess_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hf_en_q   <= (state_d != ST_LF);
      mux_sel_q <= (state_d == ST_SW_HF) || (state_d == ST_HF);
      ack_q     <= (state_d == ST_HF) || (state_d == ST_SW_LF);
      busy_q    <= (state_d == ST_START) || (state_d == ST_SW_HF) || (state_d == ST_SW_LF);
      if ((state_q == ST_SW_HF) && (state_d == ST_HF)) begin
        sess_q <= sess_q + 8'd1;
      end
    end
  end

  assign ack_hf      = ack_q;
  assign hf_en       = hf_en_q;
  assign mux_sel     = mux_sel_q;
  assign busy        = busy_q;
  assign state_o     = state_q;
  assign hf_sessions = sess_q;

endmodule
